// File: rtl/ibuf_read_pkg.sv
// Shared types and constants for the input-buffer read controller.
// Holds the controller state encoding and the post-issue drain length.
package ibuf_read_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_e;

  // The last bank-0 request still has to ripple down the skew and through the bank latency.
  function automatic int drain_cycles(input int num_banks, input int read_latency);
    return num_banks - 1 + read_latency;
  endfunction

endpackage

// File: rtl/ibuf_read_skew.sv
// Triangular delay chain: lane n carries the lane-0 input delayed by n cycles.
// Lane 0 is a combinational pass-through; the chain shifts every cycle.
module ibuf_read_skew #(
  parameter int WIDTH = 1,
  parameter int DEPTH = 2
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [WIDTH-1:0]       data_i,
  output logic [DEPTH*WIDTH-1:0] data_o
);

  assign data_o[WIDTH-1:0] = data_i;

  if (DEPTH > 1) begin : g_chain
    logic [WIDTH-1:0] stage_q [DEPTH-1];

    // NOTE: every stage is reset (not left as plain storage) so reset drops in-flight requests.
    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        for (int i = 0; i < DEPTH - 1; i++) stage_q[i] <= '0;
      end else begin
        stage_q[0] <= data_i;
        for (int i = 1; i < DEPTH - 1; i++) stage_q[i] <= stage_q[i-1];
      end
    end

    for (genvar n = 1; n < DEPTH; n++) begin : g_lane
      assign data_o[n*WIDTH +: WIDTH] = stage_q[n-1];
    end
  end

endmodule

// File: rtl/ibuf_read_ctrl.sv
// Read-side controller for the banked input buffer: walks a tile descriptor and
// issues diagonally skewed per-bank reads, returning data with a per-bank valid.
module ibuf_read_ctrl
  import ibuf_read_pkg::*;
#(
  parameter int NUM_BANKS       = 64,
  parameter int DATA_WIDTH      = 8,
  parameter int READ_ADDR_WIDTH = 8,
  parameter int READ_LATENCY_B  = 1,
  parameter int LOOP_WIDTH      = 16
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic                                 start,
  input  logic [READ_ADDR_WIDTH-1:0]           base_addr,
  input  logic [READ_ADDR_WIDTH-1:0]           row_stride,
  input  logic [LOOP_WIDTH-1:0]                num_rows,
  input  logic [LOOP_WIDTH-1:0]                num_repeats,
  input  logic                                 stall,
  output logic                                 busy,
  output logic                                 done,
  output logic [NUM_BANKS-1:0]                 bs_read_req,
  output logic [NUM_BANKS*READ_ADDR_WIDTH-1:0] bs_read_addr,
  input  logic [NUM_BANKS*DATA_WIDTH-1:0]      bs_read_data,
  output logic [NUM_BANKS*DATA_WIDTH-1:0]      sa_data,
  output logic [NUM_BANKS-1:0]                 sa_data_valid
);

  localparam int DRAIN_LEN = drain_cycles(NUM_BANKS, READ_LATENCY_B);
  localparam int DRAIN_W   = $clog2(DRAIN_LEN + 1);
  localparam int LANE_W    = READ_ADDR_WIDTH + 1;

  state_e                     state_q;
  logic                       busy_q, done_q;
  logic [READ_ADDR_WIDTH-1:0] base_q, stride_q, addr_off_q;
  logic [LOOP_WIDTH-1:0]      rows_q, reps_q, row_cnt_q, rep_cnt_q;
  logic [DRAIN_W-1:0]         drain_cnt_q;

  logic                       issue_d, last_row_d, last_rep_d;
  logic [LANE_W-1:0]          lane0_d;
  logic [NUM_BANKS*LANE_W-1:0] lanes;
  logic [NUM_BANKS-1:0]       vld_q [READ_LATENCY_B];

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    issue_d    = (state_q == ISSUE) && !stall;
    last_row_d = (row_cnt_q == rows_q - LOOP_WIDTH'(1));
    last_rep_d = (rep_cnt_q == reps_q - LOOP_WIDTH'(1));
    lane0_d    = '0;
    if (issue_d) lane0_d = {1'b1, base_q + addr_off_q};
  end

  // NOTE: sequential state uses non-blocking assignments only, so all registers update together.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      base_q      <= '0;
      stride_q    <= '0;
      rows_q      <= '0;
      reps_q      <= '0;
      row_cnt_q   <= '0;
      rep_cnt_q   <= '0;
      addr_off_q  <= '0;
      drain_cnt_q <= '0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (start) begin
            base_q     <= base_addr;
            stride_q   <= row_stride;
            rows_q     <= num_rows;
            reps_q     <= num_repeats;
            row_cnt_q  <= '0;
            rep_cnt_q  <= '0;
            addr_off_q <= '0;
            busy_q     <= 1'b1;
            if (num_rows == '0 || num_repeats == '0) begin
              state_q <= DONE;
              done_q  <= 1'b1;
            end else begin
              state_q <= ISSUE;
            end
          end
        end
        ISSUE: begin
          if (issue_d) begin
            if (last_row_d) begin
              row_cnt_q  <= '0;
              addr_off_q <= '0;
              rep_cnt_q  <= rep_cnt_q + LOOP_WIDTH'(1);
              if (last_rep_d) begin
                state_q     <= DRAIN;
                drain_cnt_q <= '0;
              end
            end else begin
              row_cnt_q  <= row_cnt_q + LOOP_WIDTH'(1);
              addr_off_q <= addr_off_q + stride_q;
            end
          end
        end
        DRAIN: begin
          if (drain_cnt_q == DRAIN_W'(DRAIN_LEN - 1)) begin
            state_q <= DONE;
            done_q  <= 1'b1;
          end else begin
            drain_cnt_q <= drain_cnt_q + DRAIN_W'(1);
          end
        end
        DONE: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  ibuf_read_skew #(
    .WIDTH (LANE_W),
    .DEPTH (NUM_BANKS)
  ) u_skew (
    .clk    (clk),
    .reset  (reset),
    .data_i (lane0_d),
    .data_o (lanes)
  );

  for (genvar n = 0; n < NUM_BANKS; n++) begin : g_bank
    assign bs_read_req[n] = lanes[n*LANE_W + READ_ADDR_WIDTH];
    assign bs_read_addr[n*READ_ADDR_WIDTH +: READ_ADDR_WIDTH] = lanes[n*LANE_W +: READ_ADDR_WIDTH];
  end

  // Valid tracks the fixed bank latency; the data itself is not re-registered.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < READ_LATENCY_B; i++) vld_q[i] <= '0;
    end else begin
      vld_q[0] <= bs_read_req;
      for (int i = 1; i < READ_LATENCY_B; i++) vld_q[i] <= vld_q[i-1];
    end
  end

  assign sa_data_valid = vld_q[READ_LATENCY_B-1];
  assign sa_data       = bs_read_data;
  assign busy          = busy_q;
  assign done          = done_q;

endmodule

// File: tb/tb_ibuf_read_ctrl.sv
// Self-checking bench for ibuf_read_ctrl: table-driven tiles with a per-bank
// scoreboard of expected requests and valids, plus reset and restart sequences.
module tb_ibuf_read_ctrl;

  localparam int NB = 4;
  localparam int DW = 8;
  localparam int AW = 8;
  localparam int RL = 1;
  localparam int LW = 16;

  logic              clk, reset, start, stall, busy, done;
  logic [AW-1:0]     base_addr, row_stride;
  logic [LW-1:0]     num_rows, num_repeats;
  logic [NB-1:0]     bs_read_req, sa_data_valid;
  logic [NB*AW-1:0]  bs_read_addr;
  logic [NB*DW-1:0]  bs_read_data, sa_data;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [AW-1:0] base;
    logic [AW-1:0] stride;
    logic [LW-1:0] rows;
    logic [LW-1:0] reps;
    logic [31:0]   stall_mask;
    int            restart_cyc;
    int            done_cyc;
  } vec_t;

  typedef struct {
    int            cyc;
    logic [AW-1:0] addr;
  } exp_t;

  exp_t rq [NB][$];
  int   vq [NB][$];
  vec_t vecs [11];

  ibuf_read_ctrl #(
    .NUM_BANKS       (NB),
    .DATA_WIDTH      (DW),
    .READ_ADDR_WIDTH (AW),
    .READ_LATENCY_B  (RL),
    .LOOP_WIDTH      (LW)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .start         (start),
    .base_addr     (base_addr),
    .row_stride    (row_stride),
    .num_rows      (num_rows),
    .num_repeats   (num_repeats),
    .stall         (stall),
    .busy          (busy),
    .done          (done),
    .bs_read_req   (bs_read_req),
    .bs_read_addr  (bs_read_addr),
    .bs_read_data  (bs_read_data),
    .sa_data       (sa_data),
    .sa_data_valid (sa_data_valid)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, " req"},   bs_read_req,   '0);
    check({tag, " addr"},  bs_read_addr,  '0);
    check({tag, " valid"}, sa_data_valid, '0);
    check({tag, " busy"},  busy,          '0);
    check({tag, " done"},  done,          '0);
  endtask

  // One tile: drive start/stall per cycle, model bank-0 issues, and score every lane.
  task automatic run_vec(input int vi, input vec_t v);
    bit            act;
    int            row, rep;
    logic [AW-1:0] a;
    logic          exp_req, exp_vld;
    exp_t          e;
    for (int k = 0; k <= v.done_cyc + 3; k++) begin
      @(posedge clk);
      #1;
      start        = 1'b0;
      stall        = v.stall_mask[k];
      bs_read_data = $urandom();
      if (k == 0) begin
        start       = 1'b1;
        base_addr   = v.base;
        row_stride  = v.stride;
        num_rows    = v.rows;
        num_repeats = v.reps;
        act = (v.rows != 0) && (v.reps != 0);
        row = 0;
        rep = 0;
      end else if (v.restart_cyc != 0 && k == v.restart_cyc) begin
        start       = 1'b1;
        base_addr   = 8'h55;
        row_stride  = 8'h09;
        num_rows    = 16'd7;
        num_repeats = 16'd7;
      end
      if (k >= 1 && act && !stall) begin
        a = AW'(int'(v.base) + row * int'(v.stride));
        for (int n = 0; n < NB; n++) begin
          rq[n].push_back('{cyc: k + n, addr: a});
          vq[n].push_back(k + n + RL);
        end
        row++;
        if (row == int'(v.rows)) begin
          row = 0;
          rep++;
          if (rep == int'(v.reps)) act = 1'b0;
        end
      end
      @(negedge clk);
      check($sformatf("v%0d c%0d busy", vi, k), busy, (k >= 1 && k <= v.done_cyc));
      check($sformatf("v%0d c%0d done", vi, k), done, (k == v.done_cyc));
      for (int n = 0; n < NB; n++) begin
        exp_req = (rq[n].size() > 0) && (rq[n][0].cyc == k);
        check($sformatf("v%0d c%0d req[%0d]", vi, k, n), bs_read_req[n], exp_req);
        if (exp_req) begin
          e = rq[n].pop_front();
          if (bs_read_req[n])
            check($sformatf("v%0d c%0d addr[%0d]", vi, k, n), bs_read_addr[n*AW +: AW], e.addr);
        end
        exp_vld = (vq[n].size() > 0) && (vq[n][0] == k);
        check($sformatf("v%0d c%0d valid[%0d]", vi, k, n), sa_data_valid[n], exp_vld);
        if (exp_vld) void'(vq[n].pop_front());
        if (sa_data_valid[n])
          check($sformatf("v%0d c%0d data[%0d]", vi, k, n), sa_data[n*DW +: DW], bs_read_data[n*DW +: DW]);
      end
    end
    for (int n = 0; n < NB; n++) begin
      check($sformatf("v%0d leftover req[%0d]", vi, n), rq[n].size(), 0);
      check($sformatf("v%0d leftover valid[%0d]", vi, n), vq[n].size(), 0);
      rq[n].delete();
      vq[n].delete();
    end
  endtask

  initial begin
    // base, stride, rows, reps, stall mask (bit k = cycle k), restart cycle, done cycle
    vecs[0]  = '{8'h10, 8'h02, 16'd3, 16'd1, 32'h0000_0000, 0, 8};
    vecs[1]  = '{8'h10, 8'h02, 16'd3, 16'd2, 32'h0000_0000, 0, 11};
    vecs[2]  = '{8'h10, 8'h02, 16'd3, 16'd1, 32'h0000_000C, 0, 10};
    vecs[3]  = '{8'hFE, 8'h01, 16'd4, 16'd1, 32'h0000_0000, 0, 9};
    vecs[4]  = '{8'h33, 8'h01, 16'd0, 16'd5, 32'h0000_0000, 0, 1};
    vecs[5]  = '{8'h33, 8'h01, 16'd3, 16'd0, 32'h0000_0000, 0, 1};
    vecs[6]  = '{8'h10, 8'h02, 16'd3, 16'd1, 32'h0000_0000, 2, 8};
    vecs[7]  = '{8'h20, 8'h30, 16'd2, 16'd1, 32'h0000_0078, 0, 7};
    vecs[8]  = '{8'h44, 8'h04, 16'd1, 16'd1, 32'h0000_0000, 6, 6};
    vecs[9]  = '{8'h81, 8'h7F, 16'd2, 16'd3, 32'h0000_0000, 0, 11};
    vecs[10] = '{8'h08, 8'h10, 16'd2, 16'd2, 32'h0000_0008, 0, 10};

    reset        = 1'b1;
    start        = 1'b0;
    stall        = 1'b0;
    base_addr    = '0;
    row_stride   = '0;
    num_rows     = '0;
    num_repeats  = '0;
    bs_read_data = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_all_zero("reset");
    reset = 1'b0;

    for (int i = 0; i < 11; i++) run_vec(i, vecs[i]);

    // Reset in the middle of ISSUE: everything drops at once and stays quiet.
    @(posedge clk);
    #1;
    start       = 1'b1;
    base_addr   = 8'h10;
    row_stride  = 8'h02;
    num_rows    = 16'd3;
    num_repeats = 16'd2;
    @(posedge clk);
    #1;
    start = 1'b0;
    @(posedge clk);
    #1;
    @(negedge clk);
    check("midrst pre req", bs_read_req, 4'b0011);
    check("midrst pre busy", busy, 1'b1);
    @(posedge clk);
    #1;
    reset = 1'b1;
    #1;
    check_all_zero("midrst async");
    @(posedge clk);
    #1;
    reset = 1'b0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      check_all_zero($sformatf("postrst c%0d", k));
    end

    run_vec(11, vecs[0]);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
